// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// pipe_stage_elastic : valid/ready pipeline register, optional skid entry,
//                      synchronous flush, hazard sideband (Tnew decremented).
// Revision: 1.0
// ============================================================================
module pipe_stage_elastic #(
    parameter int DATA_W = 128,
    parameter int DST_W  = 5,
    parameter int TNEW_W = 2,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_regwrite,
    input  logic [DST_W-1:0]  in_dst,
    input  logic [TNEW_W-1:0] in_tnew,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_regwrite,
    output logic [DST_W-1:0]  out_dst,
    output logic [TNEW_W-1:0] out_tnew,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic              accept;
    logic              drain;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic [TNEW_W-1:0] tnew_dec;

    logic [DATA_W-1:0] main_data;
    logic              main_regwrite;
    logic [DST_W-1:0]  main_dst;
    logic [TNEW_W-1:0] main_tnew;

    logic [DATA_W-1:0] skid_data;
    logic              skid_regwrite;
    logic [DST_W-1:0]  skid_dst;
    logic [TNEW_W-1:0] skid_tnew;

    // Saturating decrement: a producer already at 0 stays at 0.
    assign tnew_dec = (in_tnew == '0) ? '0 : in_tnew - 1'b1;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign drain     = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_ready_skid
            assign in_ready = (state != TWO);
        end else begin : g_ready_noskid
            assign in_ready = (state == EMPTY) | out_ready;
        end
    endgenerate

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept && (SKID != 0)) begin
                    next_state = TWO;
                    load_skid  = 1'b1;
                end else if (drain) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    next_state     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state         <= EMPTY;
            main_data     <= '0;
            main_regwrite <= 1'b0;
            main_dst      <= '0;
            main_tnew     <= '0;
        end else begin
            state <= next_state;
            if (load_main_in) begin
                main_data     <= in_data;
                main_regwrite <= in_regwrite;
                main_dst      <= in_dst;
                main_tnew     <= tnew_dec;
            end else if (load_main_skid) begin
                main_data     <= skid_data;
                main_regwrite <= skid_regwrite;
                main_dst      <= skid_dst;
                main_tnew     <= skid_tnew;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    skid_data     <= '0;
                    skid_regwrite <= 1'b0;
                    skid_dst      <= '0;
                    skid_tnew     <= '0;
                end else if (load_skid) begin
                    skid_data     <= in_data;
                    skid_regwrite <= in_regwrite;
                    skid_dst      <= in_dst;
                    skid_tnew     <= tnew_dec;
                end
            end
        end else begin : g_no_skid
            assign skid_data     = '0;
            assign skid_regwrite = 1'b0;
            assign skid_dst      = '0;
            assign skid_tnew     = '0;
        end
    endgenerate

    // Data is left stale after drain; sideband is gated so hazards see a bubble.
    assign out_data     = main_data;
    assign out_regwrite = out_valid & main_regwrite;
    assign out_dst      = out_valid ? main_dst  : '0;
    assign out_tnew     = out_valid ? main_tnew : '0;
    assign occupancy    = state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_elastic : directed bench for SKID=1 and SKID=0 instances.
// Revision: 1.0
// ============================================================================
module tb_pipe_stage_elastic;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_regwrite;
    logic [4:0]   in_dst;
    logic [1:0]   in_tnew;

    logic         in_valid, in_ready, out_valid, out_ready, out_regwrite;
    logic [127:0] in_data, out_data;
    logic [4:0]   out_dst;
    logic [1:0]   out_tnew, occupancy;

    logic         in_valid0, in_ready0, out_valid0, out_ready0, out_regwrite0;
    logic [127:0] in_data0, out_data0;
    logic [4:0]   out_dst0;
    logic [1:0]   out_tnew0, occupancy0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(128), .DST_W(5), .TNEW_W(2), .SKID(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_regwrite(in_regwrite), .in_dst(in_dst), .in_tnew(in_tnew),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_regwrite(out_regwrite), .out_dst(out_dst), .out_tnew(out_tnew),
        .occupancy(occupancy)
    );

    pipe_stage_elastic #(.DATA_W(128), .DST_W(5), .TNEW_W(2), .SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .in_regwrite(in_regwrite), .in_dst(in_dst), .in_tnew(in_tnew),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .out_regwrite(out_regwrite0), .out_dst(out_dst0), .out_tnew(out_tnew0),
        .occupancy(occupancy0)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
        in_regwrite = 1'b0; in_dst = '0; in_tnew = '0;

        // Reset state
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_tnew", out_tnew, 0);
        check("rst_out_dst", out_dst, 0);
        check("rst0_in_ready", in_ready0, 1);
        check("rst0_out_valid", out_valid0, 0);
        reset = 1'b0;

        // Streaming at full rate, 1-cycle latency
        out_ready = 1'b1; in_valid = 1'b1; in_regwrite = 1'b1;
        in_dst = 5'd5; in_tnew = 2'd2; in_data = 128'h11;
        tick();
        check("s_valid0", out_valid, 1);
        check("s_data0", out_data, 128'h11);
        check("s_tnew0", out_tnew, 1);
        check("s_dst0", out_dst, 5);
        check("s_rw0", out_regwrite, 1);
        in_data = 128'h22;
        tick();
        check("s_valid1", out_valid, 1);
        check("s_data1", out_data, 128'h22);
        in_data = 128'h33;
        tick();
        check("s_valid2", out_valid, 1);
        check("s_data2", out_data, 128'h33);
        in_valid = 1'b0;
        tick();
        check("s_drained_valid", out_valid, 0);
        check("s_drained_occ", occupancy, 0);
        check("s_drained_tnew", out_tnew, 0);
        check("s_drained_dst", out_dst, 0);
        check("s_drained_rw", out_regwrite, 0);
        check("s_drained_data_hold", out_data, 128'h33);

        // Backpressure fills skid; upstream holds C
        out_ready = 1'b0; in_valid = 1'b1; in_tnew = 2'd3; in_data = 128'hA1;
        tick();
        check("bp_occ1", occupancy, 1);
        check("bp_ready1", in_ready, 1);
        in_data = 128'hB2;
        tick();
        check("bp_occ2", occupancy, 2);
        check("bp_ready2", in_ready, 0);
        check("bp_head_a", out_data, 128'hA1);
        in_data = 128'hC3;
        tick();
        check("bp_hold_occ", occupancy, 2);
        check("bp_hold_head", out_data, 128'hA1);
        out_ready = 1'b1;
        tick();
        check("bp_head_b", out_data, 128'hB2);
        check("bp_b_tnew", out_tnew, 2);
        check("bp_b_occ", occupancy, 1);
        check("bp_b_ready", in_ready, 1);
        tick();
        check("bp_head_c", out_data, 128'hC3);
        check("bp_c_occ", occupancy, 1);
        in_valid = 1'b0;
        tick();
        check("bp_empty", out_valid, 0);

        // Tnew saturation and stall retention
        out_ready = 1'b0; in_valid = 1'b1; in_tnew = 2'd0; in_data = 128'h44;
        tick();
        check("tn_zero", out_tnew, 0);
        out_ready = 1'b1; in_tnew = 2'd3; in_data = 128'h55;
        tick();
        check("tn_three", out_tnew, 2);
        check("tn_three_data", out_data, 128'h55);
        out_ready = 1'b0; in_valid = 1'b0;
        tick(); tick(); tick();
        check("tn_stall_tnew", out_tnew, 2);
        check("tn_stall_occ", occupancy, 1);

        // Flush beats accept with two entries held
        in_valid = 1'b1; in_data = 128'h66;
        tick();
        check("fl_pre_occ", occupancy, 2);
        in_data = 128'h77; flush = 1'b1;
        tick();
        check("fl_occ", occupancy, 0);
        check("fl_valid", out_valid, 0);
        check("fl_rw", out_regwrite, 0);
        check("fl_data", out_data, 0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("fl_not_captured", out_valid, 0);

        // SKID=0: combinational ready and head replacement
        in_tnew = 2'd2; out_ready0 = 1'b0; in_valid0 = 1'b1; in_data0 = 128'h81;
        tick();
        check("n_occ", occupancy0, 1);
        check("n_data0", out_data0, 128'h81);
        in_data0 = 128'h82;
        #1;
        check("n_full_ready", in_ready0, 0);
        tick();
        check("n_stall_data", out_data0, 128'h81);
        out_ready0 = 1'b1;
        #1;
        check("n_comb_ready", in_ready0, 1);
        tick();
        check("n_replace_data", out_data0, 128'h82);
        check("n_replace_occ", occupancy0, 1);
        check("n_replace_tnew", out_tnew0, 1);
        in_data0 = 128'h83;
        tick();
        check("n_sustain_data", out_data0, 128'h83);
        in_valid0 = 1'b0;
        tick();
        check("n_empty_valid", out_valid0, 0);
        check("n_empty_occ", occupancy0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
